// File: rtl/mm_refill_ctrl.sv
// rtl/mm_refill_ctrl.sv - two-word instruction cache block refill controller
module mm_refill_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] PC,
    input  logic        HitWrite,
    input  logic        NOT_JUMPED,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_READY,
    output logic        Access_MM,
    output logic [63:0] Data_MM,
    output logic        BUSY,
    output logic        ERR,
    output logic [19:0] CNT_REFILL
);

    // Wait counter only needs to reach TIMEOUT-1; the cycle after that is the abandon point.
    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        FILL,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      base;
    logic [WCW-1:0]   wait_cnt;

    logic latch_base;
    logic cap_hi;
    logic cap_lo;
    logic set_err;
    logic clr_wait;
    logic inc_wait;
    logic inc_cnt;
    logic timed_out;

    assign timed_out = (wait_cnt == WAIT_LAST);

    // Moore outputs decoded from state and the latched block base only.
    assign MEM_RD    = (state == RD0) || (state == RD1) || (state == DRAIN);
    assign MEM_ADDR  = (state == RD1) ? (base + 32'd4) : base;
    assign Access_MM = (state == FILL);
    assign BUSY      = (state != IDLE);

    // Next-state and register-update decisions; a completion always beats the timeout.
    always_comb begin
        state_nxt  = state;
        latch_base = 1'b0;
        cap_hi     = 1'b0;
        cap_lo     = 1'b0;
        set_err    = 1'b0;
        clr_wait   = 1'b0;
        inc_wait   = 1'b0;
        inc_cnt    = 1'b0;
        case (state)
            IDLE: begin
                if (!HitWrite && NOT_JUMPED) begin
                    latch_base = 1'b1;
                    clr_wait   = 1'b1;
                    state_nxt  = RD0;
                end
            end
            RD0, RD1: begin
                if (!NOT_JUMPED) begin
                    // Stale refill: a read already in flight must be drained before going idle.
                    if (MEM_READY) begin
                        state_nxt = IDLE;
                    end else begin
                        clr_wait  = 1'b1;
                        state_nxt = DRAIN;
                    end
                end else if (MEM_READY) begin
                    clr_wait = 1'b1;
                    if (state == RD0) begin
                        cap_hi    = 1'b1;
                        state_nxt = RD1;
                    end else begin
                        cap_lo    = 1'b1;
                        state_nxt = FILL;
                    end
                end else if (timed_out) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    inc_wait = 1'b1;
                end
            end
            DRAIN: begin
                if (MEM_READY) begin
                    state_nxt = IDLE;
                end else if (timed_out) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    inc_wait = 1'b1;
                end
            end
            FILL: begin
                inc_cnt   = NOT_JUMPED;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, block base, captured data, wait counter, error flag and refill count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            base       <= 32'd0;
            wait_cnt   <= '0;
            Data_MM    <= 64'd0;
            ERR        <= 1'b0;
            CNT_REFILL <= 20'd0;
        end else begin
            state <= state_nxt;
            if (latch_base) begin
                base <= PC & ~32'h7;
            end
            if (clr_wait) begin
                wait_cnt <= '0;
            end else if (inc_wait) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (cap_hi) begin
                Data_MM[63:32] <= MEM_RDATA;
            end
            if (cap_lo) begin
                Data_MM[31:0] <= MEM_RDATA;
            end
            if (set_err) begin
                ERR <= 1'b1;
            end
            if (inc_cnt) begin
                CNT_REFILL <= CNT_REFILL + 20'd1;
            end
        end
    end

endmodule

// File: tb/tb_mm_refill_ctrl.sv
// tb/tb_mm_refill_ctrl.sv - directed self-checking bench for mm_refill_ctrl
module tb_mm_refill_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] PC;
    logic        HitWrite;
    logic        NOT_JUMPED;
    logic [31:0] MEM_ADDR;
    logic        MEM_RD;
    logic [31:0] MEM_RDATA;
    logic        MEM_READY;
    logic        Access_MM;
    logic [63:0] Data_MM;
    logic        BUSY;
    logic        ERR;
    logic [19:0] CNT_REFILL;

    int errors = 0;
    int checks = 0;
    int pulses;

    mm_refill_ctrl #(.TIMEOUT(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PC         (PC),
        .HitWrite   (HitWrite),
        .NOT_JUMPED (NOT_JUMPED),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_RD     (MEM_RD),
        .MEM_RDATA  (MEM_RDATA),
        .MEM_READY  (MEM_READY),
        .Access_MM  (Access_MM),
        .Data_MM    (Data_MM),
        .BUSY       (BUSY),
        .ERR        (ERR),
        .CNT_REFILL (CNT_REFILL)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " Access_MM"}, 64'(Access_MM), 64'd0);
        check({tag, " MEM_RD"}, 64'(MEM_RD), 64'd0);
        check({tag, " MEM_ADDR"}, 64'(MEM_ADDR), 64'd0);
        check({tag, " Data_MM"}, Data_MM, 64'd0);
        check({tag, " BUSY"}, 64'(BUSY), 64'd0);
        check({tag, " ERR"}, 64'(ERR), 64'd0);
        check({tag, " CNT_REFILL"}, 64'(CNT_REFILL), 64'd0);
    endtask

    initial begin
        RESET      = 1'b1;
        PC         = 32'd0;
        HitWrite   = 1'b1;
        NOT_JUMPED = 1'b1;
        MEM_RDATA  = 32'd0;
        MEM_READY  = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        RESET = 1'b0;
        tick();

        // Minimum-latency refill with MEM_READY tied high.
        PC = 32'h0000_0014; HitWrite = 1'b0; MEM_READY = 1'b1; MEM_RDATA = 32'hAAAA_0001;
        tick();
        HitWrite = 1'b1;
        check("t1 c1 MEM_RD", 64'(MEM_RD), 64'd1);
        check("t1 c1 MEM_ADDR", 64'(MEM_ADDR), 64'h10);
        check("t1 c1 BUSY", 64'(BUSY), 64'd1);
        tick();
        MEM_RDATA = 32'hBBBB_0002;
        check("t1 c2 MEM_ADDR", 64'(MEM_ADDR), 64'h14);
        check("t1 c2 Access_MM", 64'(Access_MM), 64'd0);
        tick();
        check("t1 c3 Access_MM", 64'(Access_MM), 64'd1);
        check("t1 c3 MEM_RD", 64'(MEM_RD), 64'd0);
        check("t1 c3 Data_MM", Data_MM, 64'hAAAA0001_BBBB0002);
        tick();
        check("t1 c4 Access_MM", 64'(Access_MM), 64'd0);
        check("t1 c4 BUSY", 64'(BUSY), 64'd0);
        check("t1 CNT_REFILL", 64'(CNT_REFILL), 64'd1);
        check("t1 Data_MM held", Data_MM, 64'hAAAA0001_BBBB0002);

        // Each word completes after four wait cycles.
        PC = 32'h0000_0100; HitWrite = 1'b0; MEM_READY = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) HitWrite = 1'b1;
            MEM_READY = (c == 5) || (c == 10);
            MEM_RDATA = 32'(c);
            check($sformatf("t2 c%0d MEM_RD", c), 64'(MEM_RD), 64'(c <= 10));
            check($sformatf("t2 c%0d MEM_ADDR", c), 64'(MEM_ADDR),
                  (c >= 6 && c <= 10) ? 64'h104 : 64'h100);
            check($sformatf("t2 c%0d Access_MM", c), 64'(Access_MM), 64'(c == 11));
            if (Access_MM) pulses++;
        end
        MEM_READY = 1'b0;
        check("t2 pulse count", 64'(pulses), 64'd1);
        check("t2 Data_MM", Data_MM, {32'd5, 32'd10});
        check("t2 CNT_REFILL", 64'(CNT_REFILL), 64'd2);

        // Redirect during RD1 with the read outstanding forces DRAIN.
        PC = 32'h0000_0200; HitWrite = 1'b0; MEM_READY = 1'b0;
        tick();
        HitWrite = 1'b1; MEM_READY = 1'b1; MEM_RDATA = 32'hDEAD_0000;
        tick();
        check("t3 c2 MEM_ADDR", 64'(MEM_ADDR), 64'h204);
        MEM_READY = 1'b0; NOT_JUMPED = 1'b0;
        tick();
        check("t3 c3 MEM_RD", 64'(MEM_RD), 64'd1);
        check("t3 c3 MEM_ADDR", 64'(MEM_ADDR), 64'h200);
        check("t3 c3 BUSY", 64'(BUSY), 64'd1);
        NOT_JUMPED = 1'b1;
        tick();
        check("t3 c4 MEM_RD", 64'(MEM_RD), 64'd1);
        check("t3 c4 Access_MM", 64'(Access_MM), 64'd0);
        MEM_READY = 1'b1;
        tick();
        MEM_READY = 1'b0;
        check("t3 c5 BUSY", 64'(BUSY), 64'd0);
        check("t3 c5 MEM_RD", 64'(MEM_RD), 64'd0);
        check("t3 c5 Access_MM", 64'(Access_MM), 64'd0);
        tick();
        check("t3 c6 Access_MM", 64'(Access_MM), 64'd0);
        check("t3 CNT_REFILL", 64'(CNT_REFILL), 64'd2);

        // Memory never answers: abandon after eight wait cycles in RD0.
        PC = 32'h0000_0300; HitWrite = 1'b0; MEM_READY = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            HitWrite = 1'b1;
            check($sformatf("t4 c%0d BUSY", c), 64'(BUSY), 64'd1);
            check($sformatf("t4 c%0d ERR", c), 64'(ERR), 64'd0);
        end
        tick();
        check("t4 ERR set", 64'(ERR), 64'd1);
        check("t4 BUSY after timeout", 64'(BUSY), 64'd0);
        PC = 32'h0000_030C; HitWrite = 1'b0; MEM_READY = 1'b1; MEM_RDATA = 32'h1111_1111;
        tick();
        HitWrite = 1'b1;
        check("t4 retry MEM_ADDR", 64'(MEM_ADDR), 64'h308);
        tick();
        MEM_RDATA = 32'h2222_2222;
        tick();
        check("t4 retry Access_MM", 64'(Access_MM), 64'd1);
        check("t4 retry Data_MM", Data_MM, 64'h11111111_22222222);
        tick();
        check("t4 CNT_REFILL", 64'(CNT_REFILL), 64'd3);
        check("t4 ERR sticky", 64'(ERR), 64'd1);

        // Reset in the middle of a refill.
        PC = 32'h0000_0400; HitWrite = 1'b0; MEM_READY = 1'b1; MEM_RDATA = 32'h3333_3333;
        tick();
        HitWrite = 1'b1;
        tick();
        check("t5 in RD1 MEM_ADDR", 64'(MEM_ADDR), 64'h404);
        RESET = 1'b1;
        tick();
        check_reset_values("t5 mid-refill reset");
        RESET = 1'b0;
        tick();
        check("t5 Access_MM after", 64'(Access_MM), 64'd0);

        // Back-to-back misses.
        PC = 32'h0000_0500; HitWrite = 1'b0; MEM_READY = 1'b1; MEM_RDATA = 32'h5555_0000;
        tick();
        check("t6 c1 MEM_ADDR", 64'(MEM_ADDR), 64'h500);
        tick();
        check("t6 c2 MEM_ADDR", 64'(MEM_ADDR), 64'h504);
        MEM_RDATA = 32'h5555_0004;
        tick();
        check("t6 c3 Access_MM", 64'(Access_MM), 64'd1);
        check("t6 c3 MEM_RD", 64'(MEM_RD), 64'd0);
        PC = 32'h0000_0508; MEM_RDATA = 32'h6666_0008;
        tick();
        check("t6 c4 MEM_RD gap", 64'(MEM_RD), 64'd0);
        check("t6 c4 CNT_REFILL", 64'(CNT_REFILL), 64'd1);
        tick();
        HitWrite = 1'b1;
        check("t6 c5 MEM_ADDR", 64'(MEM_ADDR), 64'h508);
        check("t6 c5 MEM_RD", 64'(MEM_RD), 64'd1);
        tick();
        MEM_RDATA = 32'h6666_000C;
        tick();
        check("t6 c7 Access_MM", 64'(Access_MM), 64'd1);
        check("t6 c7 Data_MM", Data_MM, 64'h66660008_6666000C);
        tick();
        check("t6 CNT_REFILL", 64'(CNT_REFILL), 64'd2);
        check("t6 BUSY", 64'(BUSY), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mm_refill_ctrl.md
MM_REFILL_CTRL -- requirements
Module: mm_refill_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255; maximum cycles a single memory read may wait before abandoning it.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port PC  input  32  fetch address presented to the instruction cache.
REQ-005 SHALL have port HitWrite  input  1  instruction cache hit/stall flag; 0 = miss pending.
REQ-006 SHALL have port NOT_JUMPED  input  1  0 = fetch stream redirected; outstanding refill is stale.
REQ-007 SHALL have port MEM_ADDR  output  32  word-aligned main-memory read address.
REQ-008 SHALL have port MEM_RD  output  1  main-memory read request.
REQ-009 SHALL have port MEM_RDATA  input  32  main-memory read data, valid when MEM_READY=1.
REQ-010 SHALL have port MEM_READY  input  1  main-memory completion strobe for the current read.
REQ-011 SHALL have port Access_MM  output  1  one-cycle strobe: Data_MM holds a complete block for the cache.
REQ-012 SHALL have port Data_MM  output  64  refill block; [63:32] = word at block offset 0, [31:0] = word at offset 1.
REQ-013 SHALL have port BUSY  output  1  1 whenever state != IDLE.
REQ-014 SHALL have port ERR  output  1  sticky memory-timeout flag.
REQ-015 SHALL have port CNT_REFILL  output  20  count of delivered refills.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, RD0, RD1, FILL, DRAIN; all outputs registered or decoded from state/registers only.
REQ-017 IDLE: when HitWrite=0 and NOT_JUMPED=1, SHALL latch BASE = {PC[31:3],3'b000} and go to RD0; otherwise stay.
REQ-018 MEM_RD SHALL be 1 exactly in RD0, RD1, DRAIN; MEM_ADDR SHALL be BASE in RD0/DRAIN, BASE+4 in RD1, BASE otherwise.
REQ-019 MEM_RD and MEM_ADDR SHALL stay stable until a cycle with MEM_READY=1; MEM_READY outside RD0/RD1/DRAIN SHALL be ignored.
REQ-020 RD0 with MEM_READY=1 and NOT_JUMPED=1: Data_MM[63:32] <= MEM_RDATA, go to RD1.
REQ-021 RD1 with MEM_READY=1 and NOT_JUMPED=1: Data_MM[31:0] <= MEM_RDATA, go to FILL.
REQ-022 RD0/RD1 with NOT_JUMPED=0: if MEM_READY=1 discard data and go to IDLE; else go to DRAIN.
REQ-023 DRAIN: stay until MEM_READY=1, then discard data and go to IDLE; Access_MM never asserted from an aborted refill.
REQ-024 FILL: Access_MM=1 for exactly one cycle, then IDLE; Data_MM SHALL hold its value through FILL and until the next RD0 capture.
REQ-025 CNT_REFILL SHALL increment by 1 at the end of FILL when NOT_JUMPED=1 in that cycle; wraps 2^20-1 -> 0.
REQ-026 Minimum miss-to-Access_MM latency with MEM_READY tied high SHALL be 3 cycles (IDLE->RD0->RD1->FILL).
REQ-027 A wait counter SHALL clear on each entry to RD0/RD1/DRAIN and increment each cycle there without MEM_READY; on reaching TIMEOUT the FSM SHALL set ERR=1 and go to IDLE.
REQ-028 ERR SHALL clear only on RESET; a set ERR does not block further refills.
REQ-029 MEM_READY=1 and the TIMEOUT limit reached in the same cycle: the completion SHALL win and no timeout is recorded.

Reset
REQ-030 RESET=1 at a clock edge SHALL force IDLE from any state, including mid-refill, with no Access_MM pulse.
REQ-031 Reset values: Access_MM=0, MEM_RD=0, MEM_ADDR=0, Data_MM=0, BUSY=0, ERR=0, CNT_REFILL=0, BASE=0, wait counter=0.

Verification
REQ-032 Miss PC=0x0000_0014, MEM_READY=1 always, RDATA 0xAAAA_0001 then 0xBBBB_0002 -> reads at 0x10, 0x14; Access_MM on cycle 3; Data_MM=0xAAAA0001_BBBB0002; CNT_REFILL=1.
REQ-033 MEM_READY delayed 4 cycles per word -> MEM_ADDR/MEM_RD stable throughout; Access_MM on cycle 11; exactly one pulse.
REQ-034 NOT_JUMPED=0 during RD1 with MEM_READY=0 -> DRAIN; MEM_RD held until MEM_READY; IDLE; no Access_MM; CNT_REFILL unchanged.
REQ-035 MEM_READY never asserted, TIMEOUT=8 -> ERR=1 after 8 wait cycles in RD0; BUSY=0 next cycle; next miss starts a new refill normally.
REQ-036 RESET=1 while in RD1 -> next cycle all outputs at REQ-031 values; no Access_MM.
REQ-037 Two back-to-back misses (HitWrite=0 again immediately after FILL) -> two complete refills, CNT_REFILL=2, no overlap of MEM_RD for distinct blocks.
